// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding request, one-cycle memory strobe, extended load result.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_STORE,
  input  logic [2:0]        REQ_FUNCT3,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  output logic              RESP_VALID,
  output logic [31:0]       RESP_RDATA,
  output logic              RESP_ERR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_CS,
  output logic              MEM_R_W,
  output logic [1:0]        MEM_BSEL,
  output logic [31:0]       MEM_WR_DATA,
  input  logic [31:0]       MEM_RD_DATA,
  output logic [1:0]        DBG_STATE
);

  // Handshake: a request is taken on a rising edge where REQ_VALID && REQ_READY;
  // REQ_READY is high only in IDLE and RESP_VALID is a single-cycle pulse.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               store_q;
  logic [2:0]         funct3_q;
  logic [MEM_AW-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               req_illegal;
  logic               req_misaligned;
  logic [31:0]        load_ext;
  logic               unused_addr_hi;

  // Upper address bits never reach memory; addresses wrap modulo 2**MEM_AW.
  assign unused_addr_hi = ^REQ_ADDR[ADDR_W-1:MEM_AW];

  always_comb begin
    if (REQ_STORE) begin
      req_illegal = REQ_FUNCT3[2] || (REQ_FUNCT3 == 3'b011);
    end else begin
      req_illegal = (REQ_FUNCT3 == 3'b011) || (REQ_FUNCT3 == 3'b110) || (REQ_FUNCT3 == 3'b111);
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    req_misaligned = 1'b0;
    if (REQ_FUNCT3[1:0] == 2'b01) req_misaligned = REQ_ADDR[0];
    if (REQ_FUNCT3[1:0] == 2'b10) req_misaligned = (REQ_ADDR[1:0] != 2'b00);
  end
`else
  assign req_misaligned = 1'b0;
`endif

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{MEM_RD_DATA[7]}}, MEM_RD_DATA[7:0]};
      3'b100:  load_ext = {24'd0, MEM_RD_DATA[7:0]};
      3'b001:  load_ext = {{16{MEM_RD_DATA[15]}}, MEM_RD_DATA[15:0]};
      3'b101:  load_ext = {16'd0, MEM_RD_DATA[15:0]};
      default: load_ext = MEM_RD_DATA;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    REQ_READY   = 1'b0;
    RESP_VALID  = 1'b0;
    MEM_CS      = 1'b0;
    MEM_R_W     = 1'b1;
    MEM_BSEL    = 2'b00;
    MEM_ADDR    = '0;
    MEM_WR_DATA = 32'd0;
    case (state_q)
      S_IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) begin
          if (req_illegal || req_misaligned) begin
            state_d = S_RESP;
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        MEM_CS      = 1'b1;
        MEM_R_W     = ~store_q;
        MEM_ADDR    = ADDR_W'(addr_q);
        MEM_BSEL    = (funct3_q[1:0] == 2'b00) ? 2'b00 :
                      (funct3_q[1:0] == 2'b01) ? 2'b01 : 2'b11;
        MEM_WR_DATA = store_q ? wdata_q : 32'd0;
        if (store_q) begin
          state_d = S_RESP;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_d = S_RESP;
        rdata_d = load_ext;
        err_d   = 1'b0;
      end
      S_RESP: begin
        RESP_VALID = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == S_IDLE && REQ_VALID) begin
        store_q  <= REQ_STORE;
        funct3_q <= REQ_FUNCT3;
        addr_q   <= REQ_ADDR[MEM_AW-1:0];
        wdata_q  <= REQ_WDATA;
      end
    end
  end

  assign RESP_RDATA = rdata_q;
  assign RESP_ERR   = err_q;
  assign DBG_STATE  = state_q;

endmodule
